// File: rtl/modbus_host_frame_mux.sv
// ---------------------------------------------------------------------------
// modbus_host_frame_mux
//
// Purpose:
//   Byte-path multiplexer between the Modbus controller, the host message byte
//   port and the UART bridge.
//   - TX: whole frames from the controller (ended by an idle gap) and whole
//     frames from a host TX FIFO are arbitrated onto the single bridge TX
//     port. The controller has priority when both are waiting.
//   - RX: bytes from the bridge are captured into a host RX FIFO, and the last
//     byte of each frame is tagged with an end-of-frame flag.
//
// Optional feature macro: MODBUS_MUX_STATS_EN
//   Defined   -> 16-bit wrapping frame counters drive o_stat_tx_frames and
//                o_stat_rx_frames.
//   Undefined -> both outputs are tied to 0 and no counter logic is built.
//
// Ports:
//   i_clk, i_rst                 clock, synchronous active-high reset
//   i_host_tx_*                  host TX byte write port (data/last/push/flush)
//   o_host_tx_ready              TX FIFO not full
//   o_host_rx_*, i_host_rx_pop   host RX FIFO head (data/eof/valid) and pop
//   i_cfg_host_rx_en             enable RX capture
//   i_ovf_clr                    clear both sticky overflow flags
//   i_ctl_tx_*, o_ctl_tx_rdy     controller TX byte stream
//   o_br_tx_*, i_br_tx_rdy       bridge TX byte stream
//   i_br_rx_b, i_br_rx_v         bridge RX byte strobe
//   i_br_frame_end               bridge end-of-frame pulse
//   o_host_tx_level/rx_level     registered FIFO occupancies
//   o_host_tx_ovf/rx_ovf         sticky overflow flags
//   o_stat_tx_frames/rx_frames   optional frame statistics
// ---------------------------------------------------------------------------
module modbus_host_frame_mux #(
    parameter int DEPTH   = 64,
    parameter int GAP_CYC = 32,
    parameter int FCW     = 8,
    localparam int AW     = $clog2(DEPTH)
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic [7:0]    i_host_tx_data,
    input  logic          i_host_tx_last,
    input  logic          i_host_tx_push,
    output logic          o_host_tx_ready,
    input  logic          i_host_tx_flush,
    output logic [7:0]    o_host_rx_data,
    output logic          o_host_rx_eof,
    output logic          o_host_rx_valid,
    input  logic          i_host_rx_pop,
    input  logic          i_cfg_host_rx_en,
    input  logic          i_ovf_clr,
    input  logic [7:0]    i_ctl_tx_b,
    input  logic          i_ctl_tx_v,
    output logic          o_ctl_tx_rdy,
    output logic [7:0]    o_br_tx_b,
    output logic          o_br_tx_v,
    input  logic          i_br_tx_rdy,
    input  logic [7:0]    i_br_rx_b,
    input  logic          i_br_rx_v,
    input  logic          i_br_frame_end,
    output logic [AW:0]   o_host_tx_level,
    output logic [AW:0]   o_host_rx_level,
    output logic          o_host_tx_ovf,
    output logic          o_host_rx_ovf,
    output logic [15:0]   o_stat_tx_frames,
    output logic [15:0]   o_stat_rx_frames
);

    localparam int          GW      = $clog2(GAP_CYC);
    localparam logic [AW:0] LV_FULL = (AW+1)'(DEPTH);
    localparam logic [GW-1:0] GAP_END = GW'(GAP_CYC - 1);

    typedef enum logic [1:0] {S_IDLE, S_CTL, S_HOST} state_t;

    state_t r_state, w_state_nxt;

    // -----------------------------------------------------------------------
    // TX FIFO state
    // -----------------------------------------------------------------------
    logic [8:0]     r_tx_mem [DEPTH];
    logic [AW-1:0]  r_tx_wp, r_tx_rp;
    logic [AW:0]    r_tx_cnt;
    logic [FCW-1:0] r_fcnt;
    logic           r_flush_pend;
    logic           r_tx_ovf;
    logic [GW-1:0]  r_gap;

    logic           w_tx_full, w_tx_empty;
    logic           w_flush_now;
    logic           w_tx_push, w_tx_drop, w_tx_pop;
    logic           w_push_last, w_pop_last;
    logic [8:0]     w_tx_head;
    logic [GW-1:0]  w_gap_nxt;

    assign w_tx_full   = (r_tx_cnt == LV_FULL);
    assign w_tx_empty  = (r_tx_cnt == '0);
    // A flush requested during a host frame waits until the arbiter is back
    // outside HOST so the frame on the wire is never truncated.
    assign w_flush_now = (r_state != S_HOST) && (i_host_tx_flush || r_flush_pend);
    assign w_tx_push   = i_host_tx_push && !w_tx_full && !w_flush_now;
    assign w_tx_drop   = i_host_tx_push &&  w_tx_full && !w_flush_now;
    assign w_tx_head   = r_tx_mem[r_tx_rp];
    assign w_push_last = w_tx_push && i_host_tx_last;
    assign w_pop_last  = w_tx_pop && w_tx_head[8];

    // -----------------------------------------------------------------------
    // Arbiter: next state and bridge/controller handshake
    // -----------------------------------------------------------------------
    always_comb begin
        w_state_nxt  = r_state;
        o_br_tx_b    = '0;
        o_br_tx_v    = 1'b0;
        o_ctl_tx_rdy = 1'b0;
        w_tx_pop     = 1'b0;
        w_gap_nxt    = '0;
        case (r_state)
            S_IDLE: begin
                // A commit arriving this cycle counts already, so HOST starts
                // on the cycle right after the last byte is pushed.
                if (i_ctl_tx_v)
                    w_state_nxt = S_CTL;
                else if (!w_flush_now && ((r_fcnt != '0) || w_push_last))
                    w_state_nxt = S_HOST;
            end
            S_CTL: begin
                o_br_tx_b    = i_ctl_tx_b;
                o_br_tx_v    = i_ctl_tx_v;
                o_ctl_tx_rdy = i_br_tx_rdy;
                w_gap_nxt    = i_ctl_tx_v ? '0 : GW'(r_gap + 1'b1);
                if (!i_ctl_tx_v && (w_gap_nxt == GAP_END))
                    w_state_nxt = S_IDLE;
            end
            S_HOST: begin
                o_br_tx_v = 1'b1;
                o_br_tx_b = w_tx_head[7:0];
                w_tx_pop  = i_br_tx_rdy && !w_tx_empty;
                if (i_br_tx_rdy && !w_tx_empty && w_tx_head[8])
                    w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
            r_gap   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_gap   <= (r_state == S_CTL) ? w_gap_nxt : '0;
        end
    end

    // -----------------------------------------------------------------------
    // TX FIFO pointers, level, frame count, flush and overflow
    // -----------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (!i_rst && w_tx_push)
            r_tx_mem[r_tx_wp] <= {i_host_tx_last, i_host_tx_data};
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_tx_wp      <= '0;
            r_tx_rp      <= '0;
            r_tx_cnt     <= '0;
            r_fcnt       <= '0;
            r_flush_pend <= 1'b0;
            r_tx_ovf     <= 1'b0;
        end else begin
            if (w_flush_now) begin
                r_tx_wp  <= '0;
                r_tx_rp  <= '0;
                r_tx_cnt <= '0;
                r_fcnt   <= '0;
            end else begin
                if (w_tx_push) r_tx_wp <= r_tx_wp + 1'b1;
                if (w_tx_pop)  r_tx_rp <= r_tx_rp + 1'b1;
                if (w_tx_push && !w_tx_pop)
                    r_tx_cnt <= r_tx_cnt + 1'b1;
                else if (!w_tx_push && w_tx_pop)
                    r_tx_cnt <= r_tx_cnt - 1'b1;
                // Saturating count of committed but unsent host frames.
                if (w_push_last && !w_pop_last) begin
                    if (r_fcnt != '1) r_fcnt <= r_fcnt + 1'b1;
                end else if (w_pop_last && !w_push_last) begin
                    if (r_fcnt != '0) r_fcnt <= r_fcnt - 1'b1;
                end
            end

            if (r_state == S_HOST && i_host_tx_flush)
                r_flush_pend <= 1'b1;
            else if (w_flush_now)
                r_flush_pend <= 1'b0;

            if (w_tx_drop)
                r_tx_ovf <= 1'b1;
            else if (i_ovf_clr)
                r_tx_ovf <= 1'b0;
        end
    end

    assign o_host_tx_ready = !w_tx_full;
    assign o_host_tx_level = r_tx_cnt;
    assign o_host_tx_ovf   = r_tx_ovf;

    // -----------------------------------------------------------------------
    // RX capture: a one-byte hold register delays each byte until we know
    // whether it is the last of its frame.
    // -----------------------------------------------------------------------
    logic [8:0]    r_rx_mem [DEPTH];
    logic [AW-1:0] r_rx_wp, r_rx_rp;
    logic [AW:0]   r_rx_cnt;
    logic          r_rx_ovf;
    logic          r_hold_v;
    logic [7:0]    r_hold_b;
    logic          r_eof_pend;

    logic          w_rx_wr, w_rx_eof;
    logic          w_rx_full, w_rx_empty;
    logic          w_rx_push, w_rx_drop, w_rx_pop;

    always_comb begin
        w_rx_wr  = 1'b0;
        w_rx_eof = 1'b0;
        if (i_cfg_host_rx_en) begin
            if (r_eof_pend) begin
                // Frame end arrived together with the byte now held.
                w_rx_wr  = r_hold_v;
                w_rx_eof = 1'b1;
            end else if (i_br_rx_v) begin
                w_rx_wr  = r_hold_v;
            end else if (i_br_frame_end && r_hold_v) begin
                w_rx_wr  = 1'b1;
                w_rx_eof = 1'b1;
            end
        end
    end

    assign w_rx_full  = (r_rx_cnt == LV_FULL);
    assign w_rx_empty = (r_rx_cnt == '0);
    assign w_rx_push  = w_rx_wr && !w_rx_full;
    assign w_rx_drop  = w_rx_wr &&  w_rx_full;
    assign w_rx_pop   = i_host_rx_pop && !w_rx_empty;

    always_ff @(posedge i_clk) begin
        if (!i_rst && w_rx_push)
            r_rx_mem[r_rx_wp] <= {w_rx_eof, r_hold_b};
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_hold_v   <= 1'b0;
            r_hold_b   <= '0;
            r_eof_pend <= 1'b0;
        end else if (!i_cfg_host_rx_en) begin
            r_hold_v   <= 1'b0;
            r_eof_pend <= 1'b0;
        end else if (i_br_rx_v) begin
            r_hold_b   <= i_br_rx_b;
            r_hold_v   <= 1'b1;
            r_eof_pend <= i_br_frame_end;
        end else if (r_eof_pend || i_br_frame_end) begin
            r_hold_v   <= 1'b0;
            r_eof_pend <= 1'b0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_rx_wp  <= '0;
            r_rx_rp  <= '0;
            r_rx_cnt <= '0;
            r_rx_ovf <= 1'b0;
        end else begin
            if (w_rx_push) r_rx_wp <= r_rx_wp + 1'b1;
            if (w_rx_pop)  r_rx_rp <= r_rx_rp + 1'b1;
            if (w_rx_push && !w_rx_pop)
                r_rx_cnt <= r_rx_cnt + 1'b1;
            else if (!w_rx_push && w_rx_pop)
                r_rx_cnt <= r_rx_cnt - 1'b1;
            if (w_rx_drop)
                r_rx_ovf <= 1'b1;
            else if (i_ovf_clr)
                r_rx_ovf <= 1'b0;
        end
    end

    // Head is gated so the data outputs read 0 whenever the FIFO is empty.
    assign o_host_rx_valid = !w_rx_empty;
    assign o_host_rx_data  = w_rx_empty ? '0   : r_rx_mem[r_rx_rp][7:0];
    assign o_host_rx_eof   = w_rx_empty ? 1'b0 : r_rx_mem[r_rx_rp][8];
    assign o_host_rx_level = r_rx_cnt;
    assign o_host_rx_ovf   = r_rx_ovf;

    // -----------------------------------------------------------------------
    // Optional frame statistics
    // -----------------------------------------------------------------------
`ifdef MODBUS_MUX_STATS_EN
    logic [15:0] r_stat_tx, r_stat_rx;
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_stat_tx <= '0;
            r_stat_rx <= '0;
        end else begin
            if (w_pop_last)           r_stat_tx <= r_stat_tx + 1'b1;
            if (w_rx_push && w_rx_eof) r_stat_rx <= r_stat_rx + 1'b1;
        end
    end
    assign o_stat_tx_frames = r_stat_tx;
    assign o_stat_rx_frames = r_stat_rx;
`else
    assign o_stat_tx_frames = '0;
    assign o_stat_rx_frames = '0;
`endif

endmodule
